// File: rtl/add_mul_seq.sv
// Sequential adder-multiplier P = (XS+XC)*Y, one radix-2 shift-add step per cycle.
// The widened sum makes P exact for every signed or unsigned operand set.
package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

module add_mul_add #(
    parameter int              W     = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s
);
    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            assign s = a + b + W'(ci);
        end else begin : g_ripple
            logic [W-1:0] c;
            assign c[0] = ci;
            for (genvar i = 0; i < W; i++) begin : g_bit
                assign s[i] = a[i] ^ b[i] ^ c[i];
                // The final carry-out is dropped: sums are taken modulo 2^W.
                if (i < W-1) begin : g_carry
                    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
                end
            end
        end
    endgenerate
endmodule

module add_mul_seq #(
    parameter int              widthX = 8,
    parameter int              widthY = 8,
    parameter lau_pkg::speed_e speed  = lau_pkg::FAST
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     TC,
    input  logic [widthX-1:0]        XS,
    input  logic [widthX-1:0]        XC,
    input  logic [widthY-1:0]        Y,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [widthX+widthY:0]   P
);
    localparam int WP = widthX + widthY + 1;
    localparam int CW = $clog2(widthX + 1);
    localparam logic [CW-1:0] CLAST = CW'(widthX);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [widthX-1:0] xs_r, xc_r;
    logic              tc_r;
    logic [widthX:0]   sreg, s_sum;
    logic [WP-1:0]     yreg, acc, acc_nx, pp;
    logic              sub;

    add_mul_add #(.W(widthX+1), .speed(speed)) u_sum (
        .a  ({tc_r & xs_r[widthX-1], xs_r}),
        .b  ({tc_r & xc_r[widthX-1], xc_r}),
        .ci (1'b0),
        .s  (s_sum)
    );

    // The sum's top bit carries negative weight in two's complement mode.
    assign sub = tc_r && (cnt == CLAST);
    assign pp  = sub ? ~yreg : yreg;

    add_mul_add #(.W(WP), .speed(speed)) u_acc (
        .a  (acc),
        .b  (pp),
        .ci (sub),
        .s  (acc_nx)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            sreg  <= '0;
            yreg  <= '0;
            xs_r  <= '0;
            xc_r  <= '0;
            tc_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    xs_r  <= XS;
                    xc_r  <= XC;
                    tc_r  <= TC;
                    yreg  <= {{(widthX+1){TC & Y[widthY-1]}}, Y};
                    state <= SUM;
                end
                SUM: begin
                    sreg  <= s_sum;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    if (sreg[0])
                        acc <= acc_nx;
                    sreg <= sreg >> 1;
                    yreg <= yreg << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CLAST)
                        state <= DONE;
                end
                DONE: if (OUT_READY)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign P         = OUT_VALID ? acc : '0;
endmodule

// File: tb/tb_add_mul_seq.sv
// Scoreboard bench for add_mul_seq at widthX=widthY=8: directed corner cases,
// backpressure, mid-op reset and randomized traffic against a reference model.
module tb_add_mul_seq;
    logic        CLK = 1'b0;
    logic        RSTn, IN_VALID, IN_READY, TC, OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [7:0]  XS, XC, Y;
    logic [16:0] P;

    int checks = 0, failures = 0;
    int rdy_mode = 0;
    bit mon_en = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] p_hold;

    always #5 CLK = ~CLK;

    add_mul_seq #(.widthX(8), .widthY(8), .speed(lau_pkg::FAST)) dut (
        .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .TC(TC), .XS(XS), .XC(XC), .Y(Y),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .P(P)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] model(input bit tc, input logic [7:0] xs, xc, y);
        longint s, yv, pr;
        logic [63:0] pb;
        if (tc) begin
            s  = longint'($signed(xs)) + longint'($signed(xc));
            yv = longint'($signed(y));
        end else begin
            s  = longint'(xs) + longint'(xc);
            yv = longint'(y);
        end
        pr = s * yv;
        pb = pr;
        return pb[16:0];
    endfunction

    // Output side: choose OUT_READY for the coming edge, then score the handshake.
    always @(negedge CLK) begin
        if (mon_en) begin
            case (rdy_mode)
                0:       OUT_READY = 1'b1;
                1:       OUT_READY = ($urandom_range(0, 3) != 0);
                default: OUT_READY = 1'b0;
            endcase
            if (!OUT_VALID)
                chk("p_zero_idle", P, 0);
            else if (OUT_READY) begin
                if (exp_q.size() == 0)
                    chk("unexpected_out", 1, 0);
                else
                    chk("p", P, exp_q.pop_front());
            end
        end
    end

    task automatic send(input bit tc, input logic [7:0] xs, xc, y,
                        input logic [16:0] e, input bit push);
        int n = 0;
        IN_VALID = 1'b1; TC = tc; XS = xs; XC = xc; Y = y;
        while (!IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            chk("in_ready_timeout", 0, 1);
            IN_VALID = 1'b0;
        end else begin
            if (push) exp_q.push_back(e);
            @(posedge CLK);
            #1;
            IN_VALID = 1'b0;
            TC = 1'($urandom); XS = 8'($urandom); XC = 8'($urandom); Y = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge CLK);
    endtask

    initial begin
        RSTn = 1'b0; IN_VALID = 1'b0; TC = 1'b0; XS = '0; XC = '0; Y = '0;
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_p", P, 0);
        RSTn = 1'b1;
        mon_en = 1'b1;

        // Latency, backpressure and acceptance on the first IDLE cycle.
        rdy_mode = 2;
        @(negedge CLK);
        send(1'b1, 8'd127, 8'd127, 8'hFD, 17'h1FD06, 1'b1);
        for (int k = 0; k <= 15; k++) begin
            @(negedge CLK);
            if (k == 9) chk("lat_early", OUT_VALID, 0);
            if (k == 10) begin
                chk("lat_valid", OUT_VALID, 1);
                chk("lat_p", P, 17'h1FD06);
                p_hold = P;
            end
            if (k > 10) begin
                chk("bp_p_stable", P, p_hold);
                chk("bp_valid", OUT_VALID, 1);
                chk("bp_in_ready", IN_READY, 0);
            end
            if (k == 11) begin
                IN_VALID = 1'b1; TC = 1'b1; XS = 8'd5; XC = 8'hFB; Y = 8'd77;
            end
        end
        #1 rdy_mode = 0;
        @(negedge CLK);
        @(negedge CLK);
        chk("hs_in_ready", IN_READY, 1);
        chk("hs_out_valid", OUT_VALID, 0);
        chk("hs_p_zero", P, 0);
        exp_q.push_back(17'h0);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        @(negedge CLK);
        chk("accept_first_idle", IN_READY, 0);
        drain();

        // Directed corners.
        send(1'b0, 8'd255, 8'd255, 8'd255, 17'h1FC02, 1'b1);
        send(1'b1, 8'h80, 8'h80, 8'h80, 17'h08000, 1'b1);
        send(1'b1, 8'd5, 8'hFB, 8'h3C, 17'h00000, 1'b1);
        drain();

        // Reset while MUL has cnt=4 aborts the op with no output.
        send(1'b1, 8'h22, 8'h11, 8'h55, 17'h0, 1'b0);
        repeat (6) @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        chk("abort_in_ready", IN_READY, 1);
        chk("abort_out_valid", OUT_VALID, 0);
        chk("abort_p", P, 0);
        send(1'b1, 8'hFF, 8'h00, 8'h07, 17'h1FFF9, 1'b1);
        drain();

        // Random traffic with output stalls.
        rdy_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            bit tc;
            logic [7:0] xs, xc, y;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            tc = 1'($urandom); xs = 8'($urandom); xc = 8'($urandom); y = 8'($urandom);
            send(tc, xs, xc, y, model(tc, xs, xc, y), 1'b1);
        end
        drain();
        rdy_mode = 0;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
